isq_ctl: RTL and testbench

- Controller for a collapsing issue queue built from ISQ_DEPTH instruction-line registers. Each line holds a wait bit and instruction flops, with controls en, clr_wat, set_wat and fls_inst.
- Owns occupancy (the lines carry no valid bit) and in-order allocation at the tail.
- Selects the oldest line with its wait bit cleared for issue, routes operand wakeups to the correct physical line, and compacts the queue after each issue.
- Sits between rename/dispatch (allocation side) and the functional-unit issue port.

---
 rtl/isq_pkg.sv | 14 +
 rtl/isq_pri_enc.sv | 27 ++
 rtl/isq_ctl.sv | 141 ++++++++++++++
 tb/tb_isq_ctl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/isq_pkg.sv
// isq_pkg: shared sizing for the collapsing issue queue.
// Holds the queue geometry used by isq_ctl and the line/datapath widths
// shared with the instruction-line and read-mux modules.
package isq_pkg;

  localparam int ISQ_DEPTH = 8;
  localparam int IDX_WIDTH = $clog2(ISQ_DEPTH);
  localparam int CNT_WIDTH = IDX_WIDTH + 1;

  // Instruction payload carried by each line (excluding the wait bit).
  localparam int INST_WIDTH = 32;
  localparam int LINE_WIDTH = INST_WIDTH + 1;

endpackage

// File: rtl/isq_pri_enc.sv
// isq_pri_enc: lowest-index-first priority encoder.
// Ports:
//   req   - request vector, bit 0 has highest priority
//   found - at least one request bit is set
//   idx   - index of the lowest set request bit (0 when none)
module isq_pri_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/isq_ctl.sv
// isq_ctl: controller for a collapsing issue queue of ISQ_DEPTH lines.
// Line 0 is the oldest. The lines carry no valid bit, so occupancy lives
// here as a counter and the valid vector is derived from it.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   alloc_vld/rdy     - dispatch handshake, new entry written at the tail
//   lin_wat           - wait bit read back from each line
//   wake_vld/idx      - operand wakeup addressed by current physical line
//   iss_rdy/vld/idx   - issue handshake, idx drives the datapath read mux
//   fls               - pipeline flush, empties the queue
//   lin_en            - per-line load enable
//   lin_src_new       - per-line source: 1 = allocation bus, 0 = line i+1
//   lin_clr_wat       - per-line wait-bit clear
//   lin_set_wat       - per-line wait-bit set (reserved, held at 0)
//   lin_fls_inst      - per-line instruction clear
//   isq_cnt/isq_empty - occupancy status
module isq_ctl
  import isq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_vld,
  output logic                 alloc_rdy,
  input  logic [ISQ_DEPTH-1:0] lin_wat,
  input  logic                 wake_vld,
  input  logic [IDX_WIDTH-1:0] wake_idx,
  input  logic                 iss_rdy,
  output logic                 iss_vld,
  output logic [IDX_WIDTH-1:0] iss_idx,
  input  logic                 fls,
  output logic [ISQ_DEPTH-1:0] lin_en,
  output logic [ISQ_DEPTH-1:0] lin_src_new,
  output logic [ISQ_DEPTH-1:0] lin_clr_wat,
  output logic [ISQ_DEPTH-1:0] lin_set_wat,
  output logic [ISQ_DEPTH-1:0] lin_fls_inst,
  output logic [CNT_WIDTH-1:0] isq_cnt,
  output logic                 isq_empty
);

  logic [CNT_WIDTH-1:0] cnt;
  logic [ISQ_DEPTH-1:0] val;
  logic [ISQ_DEPTH-1:0] elig;
  logic                 found;
  logic [IDX_WIDTH-1:0] k;
  logic                 iss;
  logic                 alc;
  logic                 wake_hit;
  logic [IDX_WIDTH-1:0] top_idx;
  logic [IDX_WIDTH-1:0] tail_idx;
  logic [IDX_WIDTH-1:0] wake_dn;

  always_comb begin
    val = '0;
    for (int i = 0; i < ISQ_DEPTH; i++) begin
      val[i] = (CNT_WIDTH'(i) < cnt);
    end
  end

  assign elig = val & ~lin_wat;

  isq_pri_enc #(
    .N (ISQ_DEPTH),
    .W (IDX_WIDTH)
  ) u_pri_enc (
    .req   (elig),
    .found (found),
    .idx   (k)
  );

  assign iss_vld   = found & ~fls;
  assign iss_idx   = k;
  assign iss       = iss_vld & iss_rdy;
  // Full queue refuses allocation even when it issues: keeps alloc_rdy
  // free of any path from iss_rdy.
  assign alloc_rdy = (cnt < CNT_WIDTH'(ISQ_DEPTH));
  assign alc       = alloc_vld & alloc_rdy & ~fls;

  // Index of the current top entry; only meaningful when cnt > 0. At a
  // full queue the low bits of cnt wrap to 0, so this still yields DEPTH-1.
  assign top_idx  = cnt[IDX_WIDTH-1:0] - IDX_WIDTH'(1);
  assign tail_idx = iss ? top_idx : cnt[IDX_WIDTH-1:0];
  assign wake_dn  = wake_idx - IDX_WIDTH'(1);
  assign wake_hit = wake_vld & val[wake_idx];

  always_comb begin
    lin_en       = '0;
    lin_src_new  = '0;
    lin_clr_wat  = '0;
    lin_fls_inst = '0;
    if (!rst_n) begin
      // Lines reset themselves; keep every control quiet.
    end else if (fls) begin
      lin_clr_wat  = '1;
      lin_fls_inst = '1;
    end else begin
      // Compaction: entries above the issued one move down by one.
      for (int i = 0; i < ISQ_DEPTH; i++) begin
        if (iss && (IDX_WIDTH'(i) >= k) && (CNT_WIDTH'(i + 1) < cnt)) begin
          lin_en[i] = 1'b1;
        end
      end
      if (alc) begin
        lin_en[tail_idx]      = 1'b1;
        lin_src_new[tail_idx] = 1'b1;
      end
      if (iss && !alc) begin
        lin_fls_inst[top_idx] = 1'b1;
        lin_clr_wat[top_idx]  = 1'b1;
      end
      // Wakeups name the line as it stands now; follow the entry if it
      // shifts this cycle, drop it if the entry itself is leaving.
      if (wake_hit) begin
        if (iss && (wake_idx > k)) begin
          lin_clr_wat[wake_dn] = 1'b1;
        end else if (!(iss && (wake_idx == k))) begin
          lin_clr_wat[wake_idx] = 1'b1;
        end
      end
    end
  end

  assign lin_set_wat = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (fls) begin
      cnt <= '0;
    end else begin
      case ({alc, iss})
        2'b10:   cnt <= cnt + CNT_WIDTH'(1);
        2'b01:   cnt <= cnt - CNT_WIDTH'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign isq_cnt   = cnt;
  assign isq_empty = (cnt == '0);

endmodule

// File: tb/tb_isq_ctl.sv
// tb_isq_ctl: directed table-driven bench for isq_ctl. Each vector gives
// the inputs for one cycle (including the line wait bits as the lines
// would hold them) plus hand-derived combinational outputs and the
// occupancy after the clock edge.
module tb_isq_ctl;
  import isq_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 alloc_vld;
  logic                 alloc_rdy;
  logic [ISQ_DEPTH-1:0] lin_wat;
  logic                 wake_vld;
  logic [IDX_WIDTH-1:0] wake_idx;
  logic                 iss_rdy;
  logic                 iss_vld;
  logic [IDX_WIDTH-1:0] iss_idx;
  logic                 fls;
  logic [ISQ_DEPTH-1:0] lin_en;
  logic [ISQ_DEPTH-1:0] lin_src_new;
  logic [ISQ_DEPTH-1:0] lin_clr_wat;
  logic [ISQ_DEPTH-1:0] lin_set_wat;
  logic [ISQ_DEPTH-1:0] lin_fls_inst;
  logic [CNT_WIDTH-1:0] isq_cnt;
  logic                 isq_empty;

  int n_tests = 0;
  int n_fail  = 0;

  isq_ctl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_vld    (alloc_vld),
    .alloc_rdy    (alloc_rdy),
    .lin_wat      (lin_wat),
    .wake_vld     (wake_vld),
    .wake_idx     (wake_idx),
    .iss_rdy      (iss_rdy),
    .iss_vld      (iss_vld),
    .iss_idx      (iss_idx),
    .fls          (fls),
    .lin_en       (lin_en),
    .lin_src_new  (lin_src_new),
    .lin_clr_wat  (lin_clr_wat),
    .lin_set_wat  (lin_set_wat),
    .lin_fls_inst (lin_fls_inst),
    .isq_cnt      (isq_cnt),
    .isq_empty    (isq_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic       wv;
    logic [2:0] wi;
    logic       ir;
    logic       fl;
    logic [7:0] wat;
    logic [7:0] en;
    logic [7:0] src;
    logic [7:0] clr;
    logic [7:0] fi;
    logic       iv;
    logic [2:0] ix;
    logic       rdy;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input int n, input vec_t v);
    string tag;
    tag       = $sformatf("v%0d", n);
    alloc_vld = v.av;
    wake_vld  = v.wv;
    wake_idx  = v.wi;
    iss_rdy   = v.ir;
    fls       = v.fl;
    lin_wat   = v.wat;
    #1;
    chk({tag, " lin_en"},       32'(lin_en),       32'(v.en));
    chk({tag, " lin_src_new"},  32'(lin_src_new),  32'(v.src));
    chk({tag, " lin_clr_wat"},  32'(lin_clr_wat),  32'(v.clr));
    chk({tag, " lin_fls_inst"}, 32'(lin_fls_inst), 32'(v.fi));
    chk({tag, " lin_set_wat"},  32'(lin_set_wat),  32'h0);
    chk({tag, " iss_vld"},      32'(iss_vld),      32'(v.iv));
    if (v.iv) chk({tag, " iss_idx"}, 32'(iss_idx), 32'(v.ix));
    chk({tag, " alloc_rdy"},    32'(alloc_rdy),    32'(v.rdy));
    @(posedge clk);
    #1;
    chk({tag, " isq_cnt"},      32'(isq_cnt),      32'(v.cnt));
    chk({tag, " isq_empty"},    32'(isq_empty),    32'(v.cnt == 4'd0));
    @(negedge clk);
  endtask

  initial begin
    //           av wv wi ir fl wat     en     src    clr    fi     iv ix rdy cnt
    vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 0, 0, 1, 1});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h01, 8'h02, 8'h02, 8'h00, 8'h00, 0, 0, 1, 2});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h03, 8'h04, 8'h04, 8'h00, 8'h00, 0, 0, 1, 3});
    vecs.push_back('{0, 1, 1, 1, 0, 8'h07, 8'h00, 8'h00, 8'h02, 8'h00, 0, 0, 1, 3});
    vecs.push_back('{0, 0, 0, 1, 0, 8'h05, 8'h02, 8'h00, 8'h04, 8'h04, 1, 1, 1, 2});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h03, 8'h04, 8'h04, 8'h00, 8'h00, 0, 0, 1, 3});
    vecs.push_back('{0, 1, 0, 0, 0, 8'h07, 8'h00, 8'h00, 8'h01, 8'h00, 0, 0, 1, 3});
    // issue k=0 + allocation + wake of line 2 (moves to line 1)
    vecs.push_back('{1, 1, 2, 1, 0, 8'h06, 8'h07, 8'h04, 8'h02, 8'h00, 1, 0, 1, 3});
    vecs.push_back('{0, 0, 0, 1, 0, 8'h05, 8'h02, 8'h00, 8'h04, 8'h04, 1, 1, 1, 2});
    // fill to eight
    vecs.push_back('{1, 0, 0, 0, 0, 8'h03, 8'h04, 8'h04, 8'h00, 8'h00, 0, 0, 1, 3});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h07, 8'h08, 8'h08, 8'h00, 8'h00, 0, 0, 1, 4});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h0F, 8'h10, 8'h10, 8'h00, 8'h00, 0, 0, 1, 5});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h1F, 8'h20, 8'h20, 8'h00, 8'h00, 0, 0, 1, 6});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h3F, 8'h40, 8'h40, 8'h00, 8'h00, 0, 0, 1, 7});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h7F, 8'h80, 8'h80, 8'h00, 8'h00, 0, 0, 1, 8});
    // full: allocation refused, wake line 5
    vecs.push_back('{1, 1, 5, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h20, 8'h00, 0, 0, 0, 8});
    // full issue k=5 with alloc_vld: shift 5,6; clear 7
    vecs.push_back('{1, 0, 0, 1, 0, 8'hDF, 8'h60, 8'h00, 8'h80, 8'h80, 1, 5, 0, 7});
    vecs.push_back('{0, 0, 0, 0, 0, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 7});
    // issue from top entry k=cnt-1
    vecs.push_back('{0, 1, 6, 0, 0, 8'h7F, 8'h00, 8'h00, 8'h40, 8'h00, 0, 0, 1, 7});
    vecs.push_back('{0, 0, 0, 1, 0, 8'h3F, 8'h00, 8'h00, 8'h40, 8'h40, 1, 6, 1, 6});
    // wake to invalid line ignored
    vecs.push_back('{0, 1, 7, 0, 0, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 6});
    // wake to the issuing entry is dropped
    vecs.push_back('{0, 1, 2, 0, 0, 8'h3F, 8'h00, 8'h00, 8'h04, 8'h00, 0, 0, 1, 6});
    vecs.push_back('{0, 1, 2, 1, 0, 8'h3B, 8'h1C, 8'h00, 8'h20, 8'h20, 1, 2, 1, 5});
    // flush with everything else active
    vecs.push_back('{1, 1, 0, 1, 1, 8'h1E, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, 0, 1, 0});
    // empty: wake ignored, no issue, allocation lands in line 0
    vecs.push_back('{1, 1, 0, 1, 0, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 0, 0, 1, 1});

    // Reset with busy inputs: all line controls must stay quiet.
    rst_n     = 1'b0;
    alloc_vld = 1'b1;
    wake_vld  = 1'b1;
    wake_idx  = 3'd0;
    iss_rdy   = 1'b1;
    fls       = 1'b1;
    lin_wat   = 8'h00;
    #2;
    chk("rst lin_en",       32'(lin_en),       32'h0);
    chk("rst lin_fls_inst", 32'(lin_fls_inst), 32'h0);
    chk("rst lin_clr_wat",  32'(lin_clr_wat),  32'h0);
    chk("rst lin_src_new",  32'(lin_src_new),  32'h0);
    chk("rst isq_cnt",      32'(isq_cnt),      32'h0);
    chk("rst iss_vld",      32'(iss_vld),      32'h0);
    chk("rst alloc_rdy",    32'(alloc_rdy),    32'h1);
    chk("rst isq_empty",    32'(isq_empty),    32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < vecs.size(); n++) apply(n, vecs[n]);

    // Grow to four entries, then pull reset between clock edges.
    alloc_vld = 1'b1;
    wake_vld  = 1'b0;
    iss_rdy   = 1'b0;
    fls       = 1'b0;
    lin_wat   = 8'hFF;
    repeat (3) @(negedge clk);
    alloc_vld = 1'b0;
    lin_wat   = 8'h00;
    #1;
    chk("pre-rst isq_cnt", 32'(isq_cnt), 32'h4);
    chk("pre-rst iss_vld", 32'(iss_vld), 32'h1);
    alloc_vld = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst isq_cnt",   32'(isq_cnt),   32'h0);
    chk("async rst iss_vld",   32'(iss_vld),   32'h0);
    chk("async rst lin_en",    32'(lin_en),    32'h0);
    chk("async rst isq_empty", 32'(isq_empty), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
